// File: rtl/station_cntrl.sv
// rtl/station_cntrl.sv - station-to-station travel sequencer with obstacle buzzer
module station_cntrl #(
  parameter int BUZZ_DIV = 12500,
  parameter int BUZZ_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic       OK2Move,
  output logic       go,
  output logic       in_transit,
  output logic [5:0] dest_ID,
  output logic       buzz,
  output logic       buzz_n
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_MOVING = 1'b1
  } state_t;

  localparam logic [1:0]        LP_OP_STOP = 2'b00;
  localparam logic [1:0]        LP_OP_GO   = 2'b01;
  localparam logic [BUZZ_W-1:0] LP_DIV_M1  = BUZZ_W'(BUZZ_DIV - 1);
  localparam logic [BUZZ_W-1:0] LP_ONE     = BUZZ_W'(1);

  state_t            r_state;
  logic              r_in_transit;
  logic [5:0]        r_dest_id;
  logic [BUZZ_W-1:0] r_buzz_cnt;
  logic              r_buzz;

  logic [1:0] w_op;
  logic       w_take_cmd;
  logic       w_take_id;
  logic       w_arrived;
  logic       w_buzz_run;

  assign w_op      = cmd[7:6];
  assign w_arrived = (ID[7:6] == 2'b00) && (ID[5:0] == r_dest_id);

  // Consume handshakes: idle discards IDs freely, moving gives commands priority
  always_comb begin
    w_take_cmd = 1'b0;
    w_take_id  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_take_cmd = cmd_rdy;
        w_take_id  = ID_vld;
      end
      ST_MOVING: begin
        w_take_cmd = cmd_rdy;
        w_take_id  = ID_vld & ~cmd_rdy;
      end
      default: begin
        w_take_cmd = 1'b0;
        w_take_id  = 1'b0;
      end
    endcase
  end

  assign clr_cmd_rdy = w_take_cmd;
  assign clr_ID_vld  = w_take_id;

  // Travel FSM: destination and in_transit change only on consumed items
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_in_transit <= 1'b0;
      r_dest_id    <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_cmd && (w_op == LP_OP_GO)) begin
            r_dest_id    <= cmd[5:0];
            r_in_transit <= 1'b1;
            r_state      <= ST_MOVING;
          end
        end
        ST_MOVING: begin
          if (w_take_cmd) begin
            if (w_op == LP_OP_STOP) begin
              r_in_transit <= 1'b0;
              r_state      <= ST_IDLE;
            end else if (w_op == LP_OP_GO) begin
              r_dest_id <= cmd[5:0];
            end
          end else if (w_take_id && w_arrived) begin
            r_in_transit <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_in_transit <= 1'b0;
        end
      endcase
    end
  end

  assign w_buzz_run = r_in_transit & ~OK2Move;

  // Buzzer divider: toggles every BUZZ_DIV cycles while blocked, parked low otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buzz_cnt <= '0;
      r_buzz     <= 1'b0;
    end else if (!w_buzz_run) begin
      r_buzz_cnt <= '0;
      r_buzz     <= 1'b0;
    end else if (r_buzz_cnt == LP_DIV_M1) begin
      r_buzz_cnt <= '0;
      r_buzz     <= ~r_buzz;
    end else begin
      r_buzz_cnt <= r_buzz_cnt + LP_ONE;
    end
  end

  assign go         = r_in_transit & OK2Move;
  assign in_transit = r_in_transit;
  assign dest_ID    = r_dest_id;
  assign buzz       = r_buzz;
  assign buzz_n     = ~r_buzz;

endmodule

// File: tb/tb_station_cntrl.sv
// tb/tb_station_cntrl.sv - scoreboard bench for station_cntrl
module tb_station_cntrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic       OK2Move;
  logic       go;
  logic       in_transit;
  logic [5:0] dest_ID;
  logic       buzz;
  logic       buzz_n;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit         is_id;
    bit         req_it;
    logic [5:0] req_dest;
    bit         follow;
  } item_t;

  item_t sb_q[$];

  station_cntrl #(.BUZZ_DIV(4), .BUZZ_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld),
    .OK2Move(OK2Move), .go(go), .in_transit(in_transit), .dest_ID(dest_ID),
    .buzz(buzz), .buzz_n(buzz_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s actual=missing required=event", nm);
  endtask

  // Upstream models: drop rdy/vld right after the edge that consumed them
  initial forever begin
    @(negedge clk);
    if (clr_cmd_rdy) begin
      @(posedge clk);
      #1 cmd_rdy = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (clr_ID_vld) begin
      @(posedge clk);
      #1 ID_vld = 1'b0;
    end
  end

  // Monitor: pop an expectation on each consume pulse, check effects one edge later
  initial begin
    int    cyc = 0;
    int    last_cyc = -10;
    bit    pend = 0;
    item_t pe;
    item_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        check("post_in_transit", in_transit, pe.req_it);
        check("post_dest_ID", dest_ID, pe.req_dest);
        check("post_go", go, pe.req_it & OK2Move);
        pend = 0;
      end
      if (clr_cmd_rdy || clr_ID_vld) begin
        check("single_clr", clr_cmd_rdy & clr_ID_vld, 0);
        if (sb_q.size() == 0) begin
          fail_now("unexpected_clr");
        end else begin
          e = sb_q.pop_front();
          check("clr_kind", clr_ID_vld, e.is_id);
          if (e.follow) check("follow_gap", cyc - last_cyc, 1);
          last_cyc = cyc;
          pe = e;
          pend = 1;
        end
      end
    end
  end

  task automatic push_item(input bit is_id, input bit it, input logic [5:0] d, input bit fol);
    item_t e;
    e.is_id = is_id;
    e.req_it = it;
    e.req_dest = d;
    e.follow = fol;
    sb_q.push_back(e);
  endtask

  task automatic wait_drop(input string nm);
    int n = 0;
    while ((cmd_rdy || ID_vld) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cmd_rdy || ID_vld) begin
      fail_now(nm);
      cmd_rdy = 1'b0;
      ID_vld  = 1'b0;
    end
  endtask

  task automatic issue_cmd(input logic [7:0] c, input bit it, input logic [5:0] d);
    @(posedge clk);
    #1;
    push_item(0, it, d, 0);
    cmd = c;
    cmd_rdy = 1'b1;
    wait_drop("cmd_timeout");
  endtask

  task automatic issue_id(input logic [7:0] i, input bit it, input logic [5:0] d);
    @(posedge clk);
    #1;
    push_item(1, it, d, 0);
    ID = i;
    ID_vld = 1'b1;
    wait_drop("id_timeout");
  endtask

  task automatic issue_both(input logic [7:0] c, input logic [7:0] i,
                            input bit it, input logic [5:0] d);
    @(posedge clk);
    #1;
    push_item(0, it, d, 0);
    push_item(1, it, d, 1);
    cmd = c;
    ID = i;
    cmd_rdy = 1'b1;
    ID_vld = 1'b1;
    wait_drop("both_timeout");
  endtask

  initial begin
    rst_n = 1'b0;
    cmd = 8'h00;
    cmd_rdy = 1'b0;
    ID = 8'h00;
    ID_vld = 1'b0;
    OK2Move = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_transit", in_transit, 0);
    check("rst_dest_ID", dest_ID, 0);
    check("rst_go", go, 0);
    check("rst_buzz", buzz, 0);
    check("rst_buzz_n", buzz_n, 1);
    check("rst_clr_cmd", clr_cmd_rdy, 0);
    check("rst_clr_id", clr_ID_vld, 0);
    rst_n = 1'b1;

    // Basic trip, wrong then right station
    issue_cmd(8'h45, 1, 6'h05);
    check("trip_go", go, 1);
    issue_id(8'h03, 1, 6'h05);
    issue_id(8'h05, 0, 6'h05);
    check("arrive_go", go, 0);

    // Invalid ID keeps moving; stop; idle discard
    issue_cmd(8'h45, 1, 6'h05);
    issue_id(8'hC5, 1, 6'h05);
    issue_cmd(8'h00, 0, 6'h05);
    issue_id(8'h05, 0, 6'h05);

    // Simultaneous stop and matching ID: command wins, ID discarded next cycle
    issue_cmd(8'h45, 1, 6'h05);
    issue_both(8'h00, 8'h05, 0, 6'h05);

    // Retarget, then reserved opcode
    issue_cmd(8'h45, 1, 6'h05);
    issue_cmd(8'h4A, 1, 6'h0A);
    issue_cmd(8'h8F, 1, 6'h0A);
    issue_cmd(8'hC3, 1, 6'h0A);

    // Buzzer: blocked while in transit
    @(posedge clk);
    #1 OK2Move = 1'b0;
    #1 check("blocked_go", go, 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("buzz_a", buzz, (k / 4) % 2);
      check("buzz_n_a", buzz_n, 1 - ((k / 4) % 2));
    end
    OK2Move = 1'b1;
    #1 check("unblocked_go", go, 1);
    @(posedge clk);
    @(negedge clk);
    check("buzz_clear", buzz, 0);
    check("buzz_n_clear", buzz_n, 1);

    // Re-block: counter must have restarted from zero
    OK2Move = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("buzz_b", buzz, (k / 4) % 2);
    end

    // Asynchronous reset mid-buzz
    #2 rst_n = 1'b0;
    #1;
    check("arst_buzz", buzz, 0);
    check("arst_buzz_n", buzz_n, 1);
    check("arst_in_transit", in_transit, 0);
    check("arst_dest_ID", dest_ID, 0);
    OK2Move = 1'b1;
    #1 check("arst_go", go, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/station_cntrl.md
Name: station_cntrl

Overview:
- Sequences the robot's travel between barcode stations.
- Accepts 8-bit commands from the UART receiver and consumes station IDs from the barcode reader's ID/ID_vld/clr_ID_vld handshake.
- Compares each consumed ID against the commanded destination and drives the motion controller's go enable.
- Sounds a piezo buzzer while the robot is in transit but blocked by an obstacle (OK2Move low).

Parameters:
- BUZZ_DIV, 12500, clk cycles per buzzer half-period (2 kHz at 50 MHz); legal range 2..65535.
- BUZZ_W, 16, buzzer counter width; must satisfy 2^BUZZ_W >= BUZZ_DIV.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd  input  8  command byte; [7:6] opcode, [5:0] station number.
- cmd_rdy  input  1  cmd is valid; held until clr_cmd_rdy.
- clr_cmd_rdy  output  1  one-cycle pulse consuming cmd.
- ID  input  8  station ID from the barcode reader; [7:6] must be 00 to be valid.
- ID_vld  input  1  ID is valid; held until clr_ID_vld.
- clr_ID_vld  output  1  one-cycle pulse consuming ID.
- OK2Move  input  1  high when no obstacle is ahead.
- go  output  1  motion enable to the motion controller.
- in_transit  output  1  high while a destination is active.
- dest_ID  output  6  current destination station.
- buzz  output  1  piezo drive.
- buzz_n  output  1  complement of buzz.

Behaviour:
- Reset values:
  - state IDLE, in_transit=0, dest_ID=0.
  - buzz=0, buzz_n=1, buzzer counter=0.
  - clr_cmd_rdy=0, clr_ID_vld=0, go=0.
- Opcodes:
  - 01 = GO to station cmd[5:0].
  - 00 = STOP.
  - 10 and 11 = reserved; consumed and ignored.
- clr_cmd_rdy and clr_ID_vld are combinational Mealy outputs of the current state and inputs. Each is high for exactly the cycle in which the item is consumed. Effects (state, in_transit, dest_ID) take place at the next clock edge.
- go = in_transit & OK2Move, combinational.
- in_transit is registered and is 1 exactly when state==MOVING.
- IDLE:
  - cmd_rdy → clr_cmd_rdy=1.
  - If opcode==01: dest_ID<=cmd[5:0], in_transit<=1, next state MOVING. Otherwise stay in IDLE.
  - ID_vld → clr_ID_vld=1 in the same cycle; the ID is discarded. This applies even when cmd_rdy is also high.
- MOVING:
  - cmd_rdy has priority over ID_vld.
  - cmd_rdy → clr_cmd_rdy=1, then by opcode:
    - 00: in_transit<=0, go to IDLE.
    - 01: dest_ID<=cmd[5:0], stay in MOVING (retarget).
    - reserved: stay, no other change.
  - When cmd_rdy is taken, ID_vld is not consumed that cycle; it remains pending for the following cycle.
  - Else ID_vld → clr_ID_vld=1, then:
    - If ID[7:6]==00 and ID[5:0]==dest_ID: in_transit<=0, go to IDLE (arrived).
    - Otherwise stay in MOVING (wrong or invalid station).
- No item is consumed twice. Both upstream blocks drop their rdy/vld the cycle after the clear, so the controller must not re-consume on that cycle.
- Buzzer:
  - Runs only when in_transit & ~OK2Move.
  - Counter increments each cycle.
  - When the counter == BUZZ_DIV-1, it wraps to 0 and buzz toggles. The period is therefore 2*BUZZ_DIV cycles with a 50% duty cycle.
  - When the run condition is false, the counter is synchronously forced to 0 and buzz=0.
  - buzz_n = ~buzz at all times.
  - The first toggle occurs BUZZ_DIV cycles after the condition rises.
- Arrival while blocked: in_transit drops, so buzz clears on the next edge.
- Asynchronous reset mid-transit returns all registers to reset values immediately. go falls in the same instant.

Test Plan:
- Basic trip:
  - Stimulus: reset; cmd=8'h45 with cmd_rdy.
  - Response: clr_cmd_rdy pulses 1 cycle; next cycle in_transit=1, dest_ID=6'h05; go=1 with OK2Move=1.
- Wrong then right station:
  - Stimulus: in transit to 05; ID=8'h03 with ID_vld.
  - Response: clr_ID_vld pulses and in_transit stays 1.
  - Stimulus: then ID=8'h05.
  - Response: clr_ID_vld pulses; next cycle in_transit=0, go=0.
- Invalid ID and idle discard:
  - Stimulus: in transit to 05; ID=8'hC5 (ID[7:6]=11).
  - Response: consumed, robot keeps moving.
  - Stimulus: in IDLE, ID_vld with ID=8'h05.
  - Response: clr_ID_vld pulses, state stays IDLE.
- Simultaneous events:
  - Stimulus: MOVING to 05; cmd=8'h00 with cmd_rdy and ID=8'h05 with ID_vld in the same cycle.
  - Response: only clr_cmd_rdy pulses that cycle and the FSM goes to IDLE; the next cycle clr_ID_vld pulses (discard).
- Retarget and reserved opcode:
  - Stimulus: MOVING to 05; cmd=8'h4A.
  - Response: dest_ID=0A, stays in transit.
  - Stimulus: cmd=8'h8F.
  - Response: consumed, dest_ID remains 0A.
- Buzzer (BUZZ_DIV=4):
  - Stimulus: in transit, OK2Move drops.
  - Response: go=0 immediately; buzz toggles every 4 cycles (first toggle 4 cycles later), buzz_n complementary.
  - Stimulus: OK2Move returns high.
  - Response: next edge buzz=0 and counter=0.
  - Stimulus: assert rst_n=0 mid-buzz.
  - Response: buzz=0, buzz_n=1, in_transit=0 asynchronously.
